// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle, then a
// sign-fix cycle that writes HI/LO and pulses done.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetFlipFlopD,
  input  logic             flushMulDiv,
  input  logic             startMulDiv,
  input  logic [2:0]       opMulDiv,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             readHiLo,
  output logic             busyMulDiv,
  output logic             stallMulDiv,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic             doneMulDiv,
  output logic             divByZero
);

  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             is_div, neg_q, neg_r;

  // operand decode: magnitudes are taken only for the signed ops
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign op_signed = ~opMulDiv[0];
  assign a_neg     = op_signed & operandA[WIDTH-1];
  assign b_neg     = op_signed & operandB[WIDTH-1];
  assign a_mag     = a_neg ? -operandA : operandA;
  assign b_mag     = b_neg ? -operandB : operandB;

  // shift-add multiply step: acc_lo holds the multiplier, product builds in {acc_hi,acc_lo}
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // restoring divide step: acc_hi is the partial remainder, acc_lo the dividend/quotient
  logic [WIDTH:0]   div_shl;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;
  assign div_shl = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = div_shl >= {1'b0, opb};
  assign div_hi  = div_ge ? (div_shl[WIDTH-1:0] - opb) : div_shl[WIDTH-1:0];
  assign div_lo  = {acc_lo[WIDTH-2:0], div_ge};

  // sign fix; a zero divisor leaves the dividend in the remainder, so HI
  // comes back as operandA once the dividend sign is reapplied
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_hi, fix_lo;
  logic               dbz;
  assign prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_s  = neg_q ? -acc_lo : acc_lo;
  assign rem_s  = neg_r ? -acc_hi : acc_hi;
  assign dbz    = (opb == '0);
  assign fix_hi = is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
  assign fix_lo = is_div ? (dbz ? '1 : quo_s) : prod_s[WIDTH-1:0];

  assign busyMulDiv  = (state != IDLE);
  assign stallMulDiv = busyMulDiv & (readHiLo | startMulDiv);

  always_ff @(posedge clock or posedge resetFlipFlopD) begin
    if (resetFlipFlopD) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opb        <= '0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hiOut      <= '0;
      loOut      <= '0;
      doneMulDiv <= 1'b0;
      divByZero  <= 1'b0;
    end else begin
      doneMulDiv <= 1'b0;
      if (flushMulDiv) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (startMulDiv) begin
            if (!opMulDiv[2]) begin
              acc_hi <= '0;
              acc_lo <= a_mag;
              opb    <= b_mag;
              is_div <= opMulDiv[1];
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              cnt    <= '0;
              state  <= RUN;
            end else if (opMulDiv == 3'b100) begin
              hiOut <= operandA;
            end else if (opMulDiv == 3'b101) begin
              loOut <= operandA;
            end
          end
          RUN: begin
            acc_hi <= is_div ? div_hi : mul_hi;
            acc_lo <= is_div ? div_lo : mul_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            hiOut      <= fix_hi;
            loOut      <= fix_lo;
            doneMulDiv <= 1'b1;
            if (is_div) divByZero <= dbz;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        resetFlipFlopD = 1'b1;
  logic        flushMulDiv = 1'b0;
  logic        startMulDiv = 1'b0;
  logic [2:0]  opMulDiv = 3'd0;
  logic [31:0] operandA = '0, operandB = '0;
  logic        readHiLo = 1'b0;
  logic        busyMulDiv, stallMulDiv, doneMulDiv, divByZero;
  logic [31:0] hiOut, loOut;

  int total = 0, bad = 0;
  logic [31:0] mhi = '0, mlo = '0;
  logic        mdbz = 1'b0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .resetFlipFlopD(resetFlipFlopD), .flushMulDiv(flushMulDiv),
    .startMulDiv(startMulDiv), .opMulDiv(opMulDiv), .operandA(operandA),
    .operandB(operandB), .readHiLo(readHiLo), .busyMulDiv(busyMulDiv),
    .stallMulDiv(stallMulDiv), .hiOut(hiOut), .loOut(loOut),
    .doneMulDiv(doneMulDiv), .divByZero(divByZero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // expected HI/LO/flag for an op, from the architectural definition
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic z);
    longint p;
    longint unsigned pu;
    int sa, sb;
    h = mhi; l = mlo; z = mdbz;
    sa = a; sb = b;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
      3'd2: begin
        z = (b == 0);
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin h = 0; l = 32'h8000_0000; end
        else begin h = sa % sb; l = sa / sb; end
      end
      3'd3: begin
        z = (b == 0);
        if (b == 0) begin h = a; l = '1; end
        else begin h = a % b; l = a / b; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    startMulDiv = 1'b1; opMulDiv = op; operandA = a; operandB = b;
    @(posedge clock); #1;
    startMulDiv = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic ez;
    int n;
    model(op, a, b, eh, el, ez);
    issue(op, a, b);
    if (!op[2]) begin
      n = 0;
      while (busyMulDiv && n < 100) begin n++; @(posedge clock); #1; end
      chk("busy_cycles", n, 33);
      chk("done", doneMulDiv, 1'b1);
    end else begin
      chk("mt_busy", busyMulDiv, 1'b0);
    end
    chk("hi", hiOut, eh);
    chk("lo", loOut, el);
    chk("dbz", divByZero, ez);
    @(posedge clock); #1;
    chk("done_once", doneMulDiv, 1'b0);
    mhi = eh; mlo = el; mdbz = ez;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hffff_ffff;
      2: return 32'h0;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic ez;
    int n, dn;

    #2;
    chk("rst_hi", hiOut, 0);
    chk("rst_lo", loOut, 0);
    chk("rst_busy", busyMulDiv, 0);
    chk("rst_done", doneMulDiv, 0);
    chk("rst_dbz", divByZero, 0);
    @(negedge clock); resetFlipFlopD = 1'b0;

    // directed corners
    do_op(3'd0, 32'hffff_ffff, 32'h2);
    do_op(3'd1, 32'hffff_ffff, 32'h2);
    do_op(3'd2, 32'hffff_fff9, 32'h2);
    do_op(3'd2, 32'h8000_0000, 32'hffff_ffff);
    do_op(3'd2, 32'hffff_fff9, 32'h0);
    do_op(3'd3, 32'h7, 32'h0);
    do_op(3'd4, 32'hdead_beef, 32'h0);
    do_op(3'd5, 32'h1234_5678, 32'h0);
    do_op(3'd6, 32'h5555_5555, 32'h0);

    // held read/start while busy: stall follows busy, the held MTHI is ignored
    ra = $urandom; rb = $urandom;
    model(3'd0, ra, rb, eh, el, ez);
    issue(3'd0, ra, rb);
    repeat (4) begin @(posedge clock); #1; end
    readHiLo = 1'b1; startMulDiv = 1'b1; opMulDiv = 3'd4; operandA = 32'h1234_5678;
    #1;
    n = 0;
    while (busyMulDiv && n < 100) begin
      chk("stall_hi", stallMulDiv, 1'b1);
      n++; @(posedge clock); #1;
    end
    chk("stall_released", stallMulDiv, 1'b0);
    readHiLo = 1'b0; startMulDiv = 1'b0;
    chk("stall_hi_val", hiOut, eh);
    chk("stall_lo_val", loOut, el);
    mhi = eh; mlo = el;
    @(posedge clock); #1;

    // reset in the middle of a divide
    do_op(3'd3, 32'h7, 32'h0);
    issue(3'd2, $urandom, 32'h3);
    repeat (10) begin @(posedge clock); #1; end
    resetFlipFlopD = 1'b1;
    #1;
    chk("mid_rst_hi", hiOut, 0);
    chk("mid_rst_lo", loOut, 0);
    chk("mid_rst_busy", busyMulDiv, 0);
    chk("mid_rst_done", doneMulDiv, 0);
    chk("mid_rst_dbz", divByZero, 0);
    @(negedge clock); resetFlipFlopD = 1'b0;
    mhi = 0; mlo = 0; mdbz = 0;
    dn = 0;
    repeat (40) begin @(posedge clock); #1; if (doneMulDiv) dn++; end
    chk("rst_no_done", dn, 0);
    do_op(3'd0, 32'hffff_ffff, 32'h2);

    // flush mid-op: HI/LO/flag untouched, no done
    issue(3'd3, 32'h9, 32'h0);
    repeat (9) begin @(posedge clock); #1; end
    @(negedge clock); flushMulDiv = 1'b1;
    @(posedge clock); #1; flushMulDiv = 1'b0;
    chk("flush_busy", busyMulDiv, 0);
    dn = 0;
    repeat (40) begin @(posedge clock); #1; if (doneMulDiv) dn++; end
    chk("flush_no_done", dn, 0);
    chk("flush_hi", hiOut, mhi);
    chk("flush_lo", loOut, mlo);
    chk("flush_dbz", divByZero, mdbz);

    // flush wins over a simultaneous start
    @(negedge clock);
    flushMulDiv = 1'b1; startMulDiv = 1'b1; opMulDiv = 3'd5; operandA = 32'hcafe_f00d;
    @(posedge clock); #1;
    flushMulDiv = 1'b0; startMulDiv = 1'b0;
    chk("flush_start_busy", busyMulDiv, 0);
    chk("flush_start_lo", loOut, mlo);

    // random mix
    repeat (60) do_op(3'($urandom_range(0, 7)), pick(), pick());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width; even values >= 4 only.
REQ-002 SHALL have port clock  in  1  rising-edge clock.
REQ-003 SHALL have port resetFlipFlopD  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port flushMulDiv  in  1  synchronous abort of the in-flight operation.
REQ-005 SHALL have port startMulDiv  in  1  EX-stage request, qualified by opMulDiv.
REQ-006 SHALL have port opMulDiv  in  3  codes: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
REQ-007 SHALL have port operandA  in  WIDTH  rs value (multiplicand/dividend, MTHI/MTLO source).
REQ-008 SHALL have port operandB  in  WIDTH  rt value (multiplier/divisor).
REQ-009 SHALL have port readHiLo  in  1  EX-stage instruction is MFHI/MFLO.
REQ-010 SHALL have port busyMulDiv  out  1  operation in progress.
REQ-011 SHALL have port stallMulDiv  out  1  combinational; drives upstream pipeline-register enables low.
REQ-012 SHALL have port hiOut  out  WIDTH  registered HI.
REQ-013 SHALL have port loOut  out  WIDTH  registered LO.
REQ-014 SHALL have port doneMulDiv  out  1  one-cycle completion pulse.
REQ-015 SHALL have port divByZero  out  1  last divide had operandB == 0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FIX.
REQ-017 In IDLE with startMulDiv=1 and op MULT/MULTU/DIV/DIVU: SHALL latch operand magnitudes (signed ops only) and result signs, load counter=0, and enter RUN at that edge (E0).
REQ-018 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring divide for divide; after WIDTH steps (edge E_WIDTH) SHALL enter FIX.
REQ-019 FIX SHALL apply signs and write hiOut/loOut at edge E_(WIDTH+1), then return to IDLE.
REQ-020 Signed multiply: SHALL produce the 2*WIDTH two's-complement product, HI = upper half, LO = lower half.
REQ-021 Signed divide: quotient is negative iff operand signs differ; remainder takes the dividend's sign; LO = quotient, HI = remainder.
REQ-022 DIV of most-negative by -1: SHALL give LO = 0x80000000 and HI = 0 (WIDTH=32), with no flag.
REQ-023 Divide by zero: SHALL keep the same latency and give HI = operandA, LO = all ones; divByZero SHALL be set at E_(WIDTH+1) and hold until the next divide completes.
REQ-024 MTHI/MTLO in IDLE: SHALL write the selected register from operandA at the same edge; no busy, no done pulse.
REQ-025 busyMulDiv SHALL be 1 while state is RUN or FIX (WIDTH+1 cycles per operation).
REQ-026 stallMulDiv SHALL equal busyMulDiv AND (readHiLo OR startMulDiv).
REQ-027 startMulDiv while busy SHALL be ignored; stalling holds the request stable for re-issue.
REQ-028 doneMulDiv SHALL pulse high for exactly the one cycle following E_(WIDTH+1).
REQ-029 flushMulDiv=1 SHALL return to IDLE at the next edge: HI/LO unchanged, no done pulse, divByZero unchanged.
REQ-030 Flush and start in the same cycle: flush SHALL win and the start is dropped.
REQ-031 hiOut/loOut SHALL change only at FIX completion or on MTHI/MTLO.

Reset
REQ-032 resetFlipFlopD=1 SHALL immediately force state IDLE, counter 0, hiOut=0, loOut=0, busyMulDiv=0, doneMulDiv=0, divByZero=0, regardless of clock.
REQ-033 Reset mid-operation SHALL discard the operation; the first start after deassertion SHALL behave as from power-up.

Verification
REQ-034 MULT A=0xFFFFFFFF, B=0x00000002 -> busy for 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE; done pulses once.
REQ-035 MULTU A=0xFFFFFFFF, B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI=7, LO=0xFFFFFFFF, divByZero=1.
REQ-037 readHiLo=1 asserted 5 cycles after a MULT start -> stallMulDiv high until busy falls; MFHI after release sees the new HI.
REQ-038 Reset pulse at cycle 10 of a DIV -> all outputs 0 immediately, no done pulse; flush at cycle 10 of a second op -> HI/LO keep their prior values.
